rd_port_arb_mux: RTL and testbench

- Parametrised N-to-1 read-port arbiter and multiplexer for a shared register-file or memory read port.
- Successor to the one-hot 8-to-1 read mux. Requesters may now assert simultaneously.
- Round-robin arbitration issues one registered read per cycle to the shared port.
- A latency-matched tag pipeline returns each read's data to the requester that issued it, with a one-hot valid.

---
 rtl/rd_port_arb_mux.sv | 149 ++++++++++++++
 tb/tb_rd_port_arb_mux.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_port_arb_mux.sv
// rd_port_arb_mux: N-to-1 round-robin read-port arbiter and multiplexer.
// Any subset of ports may request together. One winner per cycle is issued as
// a registered read to the shared port. A tag pipeline matched to the read
// latency returns the data to the port that issued it, flagged by a one-hot valid.
module rd_port_arb_mux #(
  parameter int NUM_PORTS  = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 2048,
  parameter int RD_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             port_rd_en,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  port_rd_addr,
  output logic [NUM_PORTS-1:0]             port_rd_gnt,
  output logic [NUM_PORTS-1:0]             port_rd_valid,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             muxed_port_rd_en,
  output logic [ADDR_WIDTH-1:0]            muxed_port_rd_addr,
  input  logic [DATA_WIDTH-1:0]            muxed_port_rd_data
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  // Round-robin pointer: the index that currently has highest priority.
  logic [IDX_W-1:0]      ptr_reg;
  logic [IDX_W-1:0]      ptr_next;

  // Combinational arbitration result.
  logic                  gnt_any;
  logic [IDX_W-1:0]      gnt_idx;
  logic [IDX_W:0]        cand;

  // Issue stage towards the shared port.
  logic                  rd_en_reg;
  logic [ADDR_WIDTH-1:0] rd_addr_reg;
  logic [IDX_W-1:0]      issue_idx_reg;

  // Return tag pipeline; stage RD_LATENCY-1 is the tail.
  logic [RD_LATENCY-1:0]       tag_vld_reg;
  logic [RD_LATENCY-1:0]       tag_vld_next;
  logic [RD_LATENCY*IDX_W-1:0] tag_idx_reg;
  logic [RD_LATENCY*IDX_W-1:0] tag_idx_next;
  logic [IDX_W-1:0]            tail_idx;

  // Unpacked view of the flattened address bus.
  logic [ADDR_WIDTH-1:0] addr_arr [NUM_PORTS];

  genvar gi;

  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_addr
      assign addr_arr[gi] = port_rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    end
  endgenerate

  // Search upward from the pointer, wrapping, and take the first requester.
  // The search index is one bit wider than a port index so the wrap is a
  // plain compare-and-subtract.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = {1'b0, ptr_reg} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_PORTS)) begin
        cand = cand - (IDX_W+1)'(NUM_PORTS);
      end
      if (!gnt_any && port_rd_en[cand[IDX_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[IDX_W-1:0];
      end
    end
  end

  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_gnt
      assign port_rd_gnt[gi] = gnt_any && (gnt_idx == IDX_W'(gi));
    end
  endgenerate

  // After a grant, the port just past the winner becomes highest priority.
  always_comb begin
    ptr_next = ptr_reg;
    if (gnt_any) begin
      if (gnt_idx == IDX_W'(NUM_PORTS - 1)) begin
        ptr_next = '0;
      end else begin
        ptr_next = gnt_idx + IDX_W'(1);
      end
    end
  end

  // Pointer and issue registers. The address holds when idle so the shared
  // port never sees an undefined address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_reg       <= '0;
      rd_en_reg     <= 1'b0;
      rd_addr_reg   <= '0;
      issue_idx_reg <= '0;
    end else begin
      ptr_reg   <= ptr_next;
      rd_en_reg <= gnt_any;
      if (gnt_any) begin
        rd_addr_reg   <= addr_arr[gnt_idx];
        issue_idx_reg <= gnt_idx;
      end
    end
  end

  // Tag pipeline next-state: the head takes the issued read, and every
  // later stage takes the stage before it.
  generate
    for (gi = 0; gi < RD_LATENCY; gi++) begin : g_tag
      if (gi == 0) begin : g_head
        assign tag_vld_next[0]         = rd_en_reg;
        assign tag_idx_next[0 +: IDX_W] = issue_idx_reg;
      end else begin : g_body
        assign tag_vld_next[gi]                = tag_vld_reg[gi-1];
        assign tag_idx_next[gi*IDX_W +: IDX_W] = tag_idx_reg[(gi-1)*IDX_W +: IDX_W];
      end
    end
  endgenerate

  // Advance the tag pipeline. Reset flushes it, so reads in flight are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_vld_reg <= '0;
      tag_idx_reg <= '0;
    end else begin
      tag_vld_reg <= tag_vld_next;
      tag_idx_reg <= tag_idx_next;
    end
  end

  assign tail_idx = tag_idx_reg[(RD_LATENCY-1)*IDX_W +: IDX_W];

  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_valid
      assign port_rd_valid[gi] = tag_vld_reg[RD_LATENCY-1] && (tail_idx == IDX_W'(gi));
    end
  endgenerate

  assign muxed_port_rd_en   = rd_en_reg;
  assign muxed_port_rd_addr = rd_addr_reg;
  assign rd_data            = muxed_port_rd_data;

endmodule

// File: tb/tb_rd_port_arb_mux.sv
// Testbench for rd_port_arb_mux. Two instances share one set of request
// inputs: one has a read latency of 1 and the other a read latency of 3.
// Each instance has a small behavioural memory.
// The stimulus process predicts grants and pushes the expected issues and
// returns into queues. A monitor process pops those queues and compares them
// against the outputs of both instances.
module tb_rd_port_arb_mux;

  localparam int NP = 8;
  localparam int AW = 10;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NP-1:0]    port_rd_en;
  logic [NP*AW-1:0] port_rd_addr;

  logic [NP-1:0] gnt1, valid1, gnt3, valid3;
  logic [DW-1:0] rd1, rd3, mdata1, mdata3;
  logic          men1, men3;
  logic [AW-1:0] maddr1, maddr3;

  rd_port_arb_mux #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .port_rd_en(port_rd_en), .port_rd_addr(port_rd_addr),
    .port_rd_gnt(gnt1), .port_rd_valid(valid1), .rd_data(rd1),
    .muxed_port_rd_en(men1), .muxed_port_rd_addr(maddr1), .muxed_port_rd_data(mdata1));

  rd_port_arb_mux #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .port_rd_en(port_rd_en), .port_rd_addr(port_rd_addr),
    .port_rd_gnt(gnt3), .port_rd_valid(valid3), .rd_data(rd3),
    .muxed_port_rd_en(men3), .muxed_port_rd_addr(maddr3), .muxed_port_rd_data(mdata3));

  // Memory contents: a fixed, address-dependent word.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a, 6'h15, 16'hC0DE ^ {6'b0, a}, ~a, 6'h2A, 16'h1234 + {6'b0, a}};
  endfunction

  // Shared-port memories with 1-cycle and 3-cycle read latency.
  logic [AW:0] mp1;
  logic [AW:0] mp3 [3];
  always @(posedge clk) begin
    mp1    <= {men1, maddr1};
    mp3[0] <= {men3, maddr3};
    mp3[1] <= mp3[0];
    mp3[2] <= mp3[1];
  end
  assign mdata1 = mp1[AW]    ? mem_word(mp1[AW-1:0])    : 64'hDEAD_BEEF_0BAD_F00D;
  assign mdata3 = mp3[2][AW] ? mem_word(mp3[2][AW-1:0]) : 64'hDEAD_BEEF_0BAD_F00D;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int            due;
    int            port;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t iss_q[$];
  exp_t ret1_q[$];
  exp_t ret3_q[$];

  // ---------------- monitor ----------------
  logic [AW-1:0] exp_addr;
  logic          exp_en;
  logic [NP-1:0] exp_v;
  logic [DW-1:0] exp_d;

  initial begin
    exp_addr = '0;
    forever begin
      @(negedge clk);
      #3;
      if (!rst) begin
        // Reset drops everything in flight and forces the outputs to zero.
        iss_q.delete();
        ret1_q.delete();
        ret3_q.delete();
        exp_addr = '0;
        chk("rst_en_L1",    64'(men1),   64'd0);
        chk("rst_addr_L1",  64'(maddr1), 64'd0);
        chk("rst_valid_L1", 64'(valid1), 64'd0);
        chk("rst_en_L3",    64'(men3),   64'd0);
        chk("rst_valid_L3", 64'(valid3), 64'd0);
        continue;
      end
      exp_en = 1'b0;
      if (iss_q.size() > 0 && iss_q[0].due == cyc) begin
        exp_en   = 1'b1;
        exp_addr = iss_q[0].addr;
        void'(iss_q.pop_front());
      end
      chk("issue_en_L1",   64'(men1),   64'(exp_en));
      chk("issue_addr_L1", 64'(maddr1), 64'(exp_addr));
      chk("issue_en_L3",   64'(men3),   64'(exp_en));
      chk("issue_addr_L3", 64'(maddr3), 64'(exp_addr));

      exp_v = '0;
      exp_d = '0;
      if (ret1_q.size() > 0 && ret1_q[0].due == cyc) begin
        exp_v = NP'(1 << ret1_q[0].port);
        exp_d = mem_word(ret1_q[0].addr);
        void'(ret1_q.pop_front());
      end
      chk("valid_L1", 64'(valid1), 64'(exp_v));
      if (exp_v != '0) chk("data_L1", rd1, exp_d);

      exp_v = '0;
      if (ret3_q.size() > 0 && ret3_q[0].due == cyc) begin
        exp_v = NP'(1 << ret3_q[0].port);
        exp_d = mem_word(ret3_q[0].addr);
        void'(ret3_q.pop_front());
      end
      chk("valid_L3", 64'(valid3), 64'(exp_v));
      if (exp_v != '0) chk("data_L3", rd3, exp_d);
      chk("passthru_L3", rd3, mdata3);
    end
  end

  // ---------------- stimulus + reference model ----------------
  logic [NP-1:0] req_en;
  logic [AW-1:0] req_addr [NP];
  int            m_ptr;
  int            last_g;
  logic [NP-1:0] exp_gnt;

  // One cycle: drive the pending requests, predict the round-robin winner,
  // and record when its issue and return must appear.
  task automatic do_cycle();
    @(negedge clk);
    port_rd_en = req_en;
    for (int i = 0; i < NP; i++) port_rd_addr[i*AW +: AW] = req_addr[i];
    #1;
    last_g = -1;
    for (int k = 0; k < NP; k++) begin
      int p;
      p = (m_ptr + k) % NP;
      if (last_g < 0 && req_en[p]) last_g = p;
    end
    exp_gnt = (last_g >= 0) ? NP'(1 << last_g) : '0;
    chk("gnt_L1", 64'(gnt1), 64'(exp_gnt));
    chk("gnt_L3", 64'(gnt3), 64'(exp_gnt));
    if (last_g >= 0) begin
      iss_q.push_back('{cyc + 1, last_g, req_addr[last_g]});
      ret1_q.push_back('{cyc + 2, last_g, req_addr[last_g]});
      ret3_q.push_back('{cyc + 4, last_g, req_addr[last_g]});
      m_ptr = (last_g + 1) % NP;
      req_en[last_g] = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    req_en = '0;
    repeat (n) do_cycle();
  endtask

  // Asynchronous reset asserted between clock edges, held for a few cycles.
  task automatic do_reset(input int hold);
    @(negedge clk);
    rst        = 1'b0;
    req_en     = '0;
    port_rd_en = '0;
    m_ptr      = 0;
    #1;
    chk("arst_en_L1",    64'(men1),   64'd0);
    chk("arst_addr_L1",  64'(maddr1), 64'd0);
    chk("arst_en_L3",    64'(men3),   64'd0);
    chk("arst_valid_L3", 64'(valid3), 64'd0);
    repeat (hold) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    req_en       = '0;
    port_rd_en   = '0;
    port_rd_addr = '0;
    m_ptr        = 0;
    for (int i = 0; i < NP; i++) req_addr[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Single request from port 3.
    req_en[3] = 1'b1; req_addr[3] = 10'h155;
    do_cycle();
    idle(5);

    // All ports requesting continuously right after reset.
    do_reset(2);
    for (int i = 0; i < NP; i++) req_addr[i] = AW'(10'h10 + i);
    for (int c = 0; c < 10; c++) begin
      req_en = '1;
      do_cycle();
    end
    idle(5);

    // Fairness between ports 3 and 5.
    for (int c = 0; c < 8; c++) begin
      req_en[3] = 1'b1; req_addr[3] = AW'($urandom);
      req_en[5] = 1'b1; req_addr[5] = AW'($urandom);
      do_cycle();
    end
    idle(5);

    // Single read from port 6 (the latency-3 instance returns it 4 cycles after the grant).
    req_en[6] = 1'b1; req_addr[6] = 10'h0C6;
    do_cycle();
    idle(7);

    // A read to 0x2A, then five idle cycles, then the pointer decides between ports 0 and 7.
    req_en[2] = 1'b1; req_addr[2] = 10'h02A;
    do_cycle();
    idle(5);
    req_en[0] = 1'b1; req_addr[0] = 10'h300;
    req_en[7] = 1'b1; req_addr[7] = 10'h307;
    do_cycle();
    do_cycle();
    idle(5);

    // Reset while a read from port 1 is in flight.
    req_en[1] = 1'b1; req_addr[1] = 10'h3F1;
    do_cycle();
    do_reset(2);
    req_en[5] = 1'b1; req_addr[5] = 10'h155;
    req_en[2] = 1'b1; req_addr[2] = 10'h0AA;
    do_cycle();
    do_cycle();
    idle(6);

    // Randomized traffic: every port holds its request until it is granted.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NP; i++) begin
        if (!req_en[i] && ($urandom_range(0, 2) == 0)) begin
          req_en[i]   = 1'b1;
          req_addr[i] = AW'($urandom);
        end
      end
      do_cycle();
    end

    // Drain: every expected issue and return must have been seen.
    idle(8);
    chk("drain_issue", 64'(iss_q.size()),  64'd0);
    chk("drain_ret_L1", 64'(ret1_q.size()), 64'd0);
    chk("drain_ret_L3", 64'(ret3_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
